weak_pull_bank: RTL and testbench



---
 rtl/weak_pull_pkg.sv | 34 +++
 rtl/weak_pull_chan.sv | 130 +++++++++++++
 rtl/weak_pull_bank.sv | 46 ++++
 tb/tb_weak_pull_bank.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/weak_pull_pkg.sv
// weak_pull_pkg
// Shared definitions for the weak-pull lane bank: the per-lane state
// encoding, the two-bit pull mode codes and small helpers that turn a
// mode into the level its weak pull settles to.
package weak_pull_pkg;

    // Per-lane state. FLOAT has no defined value, DRIVEN follows the strong
    // driver, SETTLING waits out the settle delay, PULLED sits at the pull
    // level and HELD is a keeper retaining the last known value.
    typedef enum logic [2:0] {
        ST_FLOAT    = 3'd0,
        ST_DRIVEN   = 3'd1,
        ST_SETTLING = 3'd2,
        ST_PULLED   = 3'd3,
        ST_HELD     = 3'd4
    } lane_state_t;

    localparam logic [1:0] PM_NONE = 2'b00;
    localparam logic [1:0] PM_DOWN = 2'b01;
    localparam logic [1:0] PM_UP   = 2'b10;
    localparam logic [1:0] PM_KEEP = 2'b11;

    // Level a pulling mode drives the lane towards (only meaningful for
    // PM_DOWN and PM_UP).
    function automatic logic pull_target(input logic [1:0] mode);
        return (mode == PM_UP);
    endfunction

    // True for the two modes that actively pull to a fixed level.
    function automatic logic is_pull(input logic [1:0] mode);
        return (mode == PM_DOWN) || (mode == PM_UP);
    endfunction

endpackage

// File: rtl/weak_pull_chan.sv
// weak_pull_chan
// One lane of the weak-pull bank: a strong driver sitting over a weak
// pull whose kind is chosen by mode. Releasing the strong driver, or
// changing the mode while released, starts a settle delay of SETTLE
// cycles before the weak level (or float) takes effect.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   drv_en     strong-drive enable
//   drv_val    strong-drive value
//   mode       pull mode (00 none, 01 down, 10 up, 11 keeper)
//   bus_val    resolved lane value (registered)
//   bus_known  1 when bus_val is defined, 0 when the lane floats
//   settling   1 while the settle delay is running
module weak_pull_chan
    import weak_pull_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       drv_en,
    input  logic       drv_val,
    input  logic [1:0] mode,
    output logic       bus_val,
    output logic       bus_known,
    output logic       settling
);

    // A zero-cycle settle never uses the counter, but keep it one bit wide
    // so the declarations stay legal.
    localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    lane_state_t      state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             val_next, known_next;
    logic [1:0]       last_mode;
    logic [1:0]       settle_mode, settle_mode_next;
    logic             mode_changed;

    // State register. Reset returns to FLOAT and treats the remembered
    // mode as "none", so a pulling mode present when reset drops counts as
    // a fresh mode change and starts the lane settling.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_FLOAT;
            cnt         <= '0;
            bus_val     <= 1'b0;
            bus_known   <= 1'b0;
            last_mode   <= PM_NONE;
            settle_mode <= PM_NONE;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            bus_val     <= val_next;
            bus_known   <= known_next;
            last_mode   <= mode;
            settle_mode <= settle_mode_next;
        end
    end

    assign mode_changed = (mode != last_mode);
    assign settling     = (state == ST_SETTLING);

    // Next-state logic. Strong drive wins outright. A release, or a mode
    // change while released, re-evaluates from the current outputs. The
    // counter is loaded with 1 on the edge that starts settling, so the
    // edge that finds it equal to SETTLE is exactly SETTLE edges later.
    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        val_next         = bus_val;
        known_next       = bus_known;
        settle_mode_next = settle_mode;

        if (drv_en) begin
            state_next = ST_DRIVEN;
            val_next   = drv_val;
            known_next = 1'b1;
            cnt_next   = '0;
        end else if ((state == ST_DRIVEN) || mode_changed) begin
            cnt_next = '0;
            if (is_pull(mode)) begin
                if (bus_known && (bus_val == pull_target(mode))) begin
                    state_next = ST_PULLED;
                end else if (SETTLE == 0) begin
                    state_next = ST_PULLED;
                    val_next   = pull_target(mode);
                    known_next = 1'b1;
                end else begin
                    state_next       = ST_SETTLING;
                    settle_mode_next = mode;
                    cnt_next         = CNT_ONE;
                end
            end else if (mode == PM_KEEP) begin
                state_next = bus_known ? ST_HELD : ST_FLOAT;
            end else begin
                // No pull: a known value decays to float after the delay.
                if (!bus_known || (SETTLE == 0)) begin
                    state_next = ST_FLOAT;
                    val_next   = 1'b0;
                    known_next = 1'b0;
                end else begin
                    state_next       = ST_SETTLING;
                    settle_mode_next = mode;
                    cnt_next         = CNT_ONE;
                end
            end
        end else if (state == ST_SETTLING) begin
            if (cnt == SETTLE_C) begin
                cnt_next = '0;
                if (settle_mode == PM_NONE) begin
                    state_next = ST_FLOAT;
                    val_next   = 1'b0;
                    known_next = 1'b0;
                end else begin
                    state_next = ST_PULLED;
                    val_next   = pull_target(settle_mode);
                    known_next = 1'b1;
                end
            end else begin
                cnt_next = cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/weak_pull_bank.sv
// weak_pull_bank
// CHANNELS independent weak-pull lanes, each a strong driver over a
// selectable weak pull (none, pulldown, pullup, keeper) with a shared
// settle delay of SETTLE cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   drv_en     per-lane strong-drive enable
//   drv_val    per-lane strong-drive value
//   pull_mode  per-lane mode, lane i at [2i+1:2i]
//   bus_val    per-lane resolved value (registered)
//   bus_known  per-lane defined flag
//   settling   per-lane settle-in-progress flag
module weak_pull_bank
    import weak_pull_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int SETTLE   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   drv_en,
    input  logic [CHANNELS-1:0]   drv_val,
    input  logic [2*CHANNELS-1:0] pull_mode,
    output logic [CHANNELS-1:0]   bus_val,
    output logic [CHANNELS-1:0]   bus_known,
    output logic [CHANNELS-1:0]   settling
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        weak_pull_chan #(
            .SETTLE(SETTLE)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .drv_en   (drv_en[i]),
            .drv_val  (drv_val[i]),
            .mode     (pull_mode[2*i +: 2]),
            .bus_val  (bus_val[i]),
            .bus_known(bus_known[i]),
            .settling (settling[i])
        );
    end

endmodule

// File: tb/tb_weak_pull_bank.sv
// tb_weak_pull_bank
// Bench for weak_pull_bank. A lane model tracks each lane as a value, a
// known flag and an optional pending outcome with the cycle it lands on;
// a compare process checks every lane every cycle against it. Directed
// sequences with literal expectations come first, then random traffic.
module tb_weak_pull_bank;

    localparam int CH     = 8;
    localparam int SETTLE = 4;

    logic            clk;
    logic            rst;
    logic [CH-1:0]   drv_en;
    logic [CH-1:0]   drv_val;
    logic [2*CH-1:0] pull_mode;
    logic [CH-1:0]   bus_val;
    logic [CH-1:0]   bus_known;
    logic [CH-1:0]   settling;

    int vectors;
    int miscompares;

    weak_pull_bank #(
        .CHANNELS(CH),
        .SETTLE  (SETTLE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .drv_en   (drv_en),
        .drv_val  (drv_val),
        .pull_mode(pull_mode),
        .bus_val  (bus_val),
        .bus_known(bus_known),
        .settling (settling)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Lane model: current value/known, whether the lane was strongly driven
    // on the previous edge, the last mode seen, and a pending outcome that
    // lands on edge number m_end.
    bit       m_val   [CH];
    bit       m_known [CH];
    bit       m_drv   [CH];
    bit [1:0] m_last  [CH];
    bit       m_pend  [CH];
    bit       m_fval  [CH];
    bit       m_fknown[CH];
    int       m_end   [CH];
    int       cyc;
    bit [1:0] md;
    bit       tgt;

    initial begin
        cyc = 0;
        for (int i = 0; i < CH; i++) begin
            m_val[i] = 0; m_known[i] = 0; m_drv[i] = 0; m_last[i] = 0;
            m_pend[i] = 0; m_fval[i] = 0; m_fknown[i] = 0; m_end[i] = 0;
        end
    end

    // Advance the model on every rising edge from the inputs sampled there.
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < CH; i++) begin
            md = pull_mode[2*i +: 2];
            if (rst) begin
                m_val[i] = 0; m_known[i] = 0; m_pend[i] = 0;
                m_drv[i] = 0; m_last[i] = 2'b00;
            end else begin
                if (drv_en[i]) begin
                    m_val[i] = drv_val[i]; m_known[i] = 1; m_pend[i] = 0;
                end else if (m_drv[i] || (md != m_last[i])) begin
                    m_pend[i] = 0;
                    if (md == 2'b01 || md == 2'b10) begin
                        tgt = (md == 2'b10);
                        if (!(m_known[i] && m_val[i] == tgt)) begin
                            if (SETTLE == 0) begin
                                m_val[i] = tgt; m_known[i] = 1;
                            end else begin
                                m_pend[i] = 1; m_fval[i] = tgt; m_fknown[i] = 1;
                                m_end[i] = cyc + SETTLE;
                            end
                        end
                    end else if (md == 2'b00) begin
                        if (!m_known[i] || SETTLE == 0) begin
                            m_val[i] = 0; m_known[i] = 0;
                        end else begin
                            m_pend[i] = 1; m_fval[i] = 0; m_fknown[i] = 0;
                            m_end[i] = cyc + SETTLE;
                        end
                    end
                end else if (m_pend[i] && cyc == m_end[i]) begin
                    m_val[i] = m_fval[i]; m_known[i] = m_fknown[i]; m_pend[i] = 0;
                end
                m_drv[i]  = drv_en[i];
                m_last[i] = md;
            end
        end
    end

    logic [CH-1:0] exp_val, exp_known, exp_settle;

    // Check every lane against the model on each falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < CH; i++) begin
            exp_val[i]    = m_val[i];
            exp_known[i]  = m_known[i];
            exp_settle[i] = m_pend[i];
        end
        vectors = vectors + 3;
        if (bus_val !== exp_val) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL model_bus_val cyc=%0d got=%b want=%b", cyc, bus_val, exp_val);
        end
        if (bus_known !== exp_known) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL model_bus_known cyc=%0d got=%b want=%b", cyc, bus_known, exp_known);
        end
        if (settling !== exp_settle) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL model_settling cyc=%0d got=%b want=%b", cyc, settling, exp_settle);
        end
    end

    task automatic applyStimulus(input logic r, input logic [CH-1:0] en,
                                 input logic [CH-1:0] val, input logic [2*CH-1:0] mode);
        rst       = r;
        drv_en    = en;
        drv_val   = val;
        pull_mode = mode;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [CH-1:0] act,
                               input logic [CH-1:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s got=%b want=%b", name, act, exp);
        end
    endtask

    logic [CH-1:0] tab_val    [5];
    logic [CH-1:0] tab_known  [5];
    logic [CH-1:0] tab_settle [5];

    initial begin
        vectors     = 0;
        miscompares = 0;
        tab_val    = '{8'h1B, 8'h1B, 8'h1B, 8'h1B, 8'h12};
        tab_known  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF7};
        tab_settle = '{8'h19, 8'h19, 8'h09, 8'h09, 8'h00};

        $display("[TB] reset, all lanes pulldown");
        applyStimulus(1'b1, '0, '0, {CH{2'b01}});
        tick();
        tick();
        checkOutput("reset_val", bus_val, 8'h00);
        checkOutput("reset_known", bus_known, 8'h00);
        checkOutput("reset_settling", settling, 8'h00);
        applyStimulus(1'b0, '0, '0, {CH{2'b01}});
        for (int k = 1; k <= 4; k++) begin
            tick();
            checkOutput("init_settling", settling, 8'hFF);
            checkOutput("init_known", bus_known, 8'h00);
        end
        tick();
        checkOutput("init_done_known", bus_known, 8'hFF);
        checkOutput("init_done_val", bus_val, 8'h00);
        checkOutput("init_done_settling", settling, 8'h00);

        $display("[TB] lanes 0-4: down/up/keep/none/down release");
        applyStimulus(1'b0, 8'h1F, 8'h1B, 16'h5539);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("drive_val", bus_val, 8'h1B);
            checkOutput("drive_settling", settling, 8'h00);
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 16'h5539);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) applyStimulus(1'b0, 8'h10, 8'h10, 16'h5539);
            tick();
            checkOutput($sformatf("release_val_%0d", k), bus_val, tab_val[k]);
            checkOutput($sformatf("release_known_%0d", k), bus_known, tab_known[k]);
            checkOutput($sformatf("release_settling_%0d", k), settling, tab_settle[k]);
        end

        $display("[TB] keeper lane idle");
        applyStimulus(1'b0, 8'h00, 8'h00, 16'h5539);
        for (int k = 0; k < 50; k++) begin
            tick();
            checkOutput("keeper_val", {7'b0, bus_val[2]}, 8'h00);
            checkOutput("keeper_known", {7'b0, bus_known[2]}, 8'h01);
        end

        $display("[TB] reset during settle");
        applyStimulus(1'b0, 8'h10, 8'h10, 16'h5539);
        tick();
        applyStimulus(1'b0, 8'h00, 8'h00, 16'h5539);
        tick();
        tick();
        checkOutput("pre_reset_settling", {7'b0, settling[4]}, 8'h01);
        applyStimulus(1'b1, 8'h00, 8'h00, 16'h5539);
        tick();
        checkOutput("midreset_val", bus_val, 8'h00);
        checkOutput("midreset_known", bus_known, 8'h00);
        checkOutput("midreset_settling", settling, 8'h00);

        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            logic [CH-1:0]   en, val;
            logic [2*CH-1:0] mode;
            mode = pull_mode;
            for (int i = 0; i < CH; i++) begin
                en[i]  = ($urandom_range(0, 7) == 0);
                val[i] = $urandom_range(0, 1) == 1;
                if ($urandom_range(0, 15) == 0) mode[2*i +: 2] = 2'($urandom_range(0, 3));
            end
            applyStimulus($urandom_range(0, 199) == 0, en, val, mode);
            tick();
        end
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
